// File: rtl/riscado_pkg.sv
// -----------------------------------------------------------------------------
// riscado_pkg
// Shared definitions for the riscado-v front end.
//   XLEN / INSTR_W    : datapath and instruction widths
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   fetch_entry_t     : one (pc, instr) pair as handed to decode
//   word_align()      : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package riscado_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// Two-entry FIFO that absorbs the ROM's one-cycle read latency between the
// fetch PC logic and decode. Push and pop may happen in the same cycle; flush
// empties the buffer and overrides any push/pop in that cycle.
//
// Ports:
//   clk          in   clock, rising edge
//   i_srst       in   synchronous active-high reset
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   W-bit entry to store
//   i_pop        in   drop the head entry
//   i_flush      in   discard all entries
//   o_count      out  number of valid entries (0..2)
//   o_head       out  head entry (meaningful while o_count != 0)
// -----------------------------------------------------------------------------
module fetch_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic         w_do_push;
  logic         w_do_pop;

  // The upstream issue rule keeps the buffer from overflowing; the full/empty
  // guards only keep the pointers coherent if that rule were ever broken.
  assign w_do_push = i_push & ~i_flush & (r_count != 2'd2);
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_srst) begin
          r_mem[gi] <= '0;
        end else if (w_do_push && (r_wr_ptr == 1'(gi))) begin
          r_mem[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_srst || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // A push never lands on the head slot while it is occupied, so the head
  // stays stable while decode stalls.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage of the riscado-v core. Holds the PC, drives the
// synchronous instruction ROM and hands (pc, instr) pairs to decode over a
// valid/ready handshake. A redirect is issued in the same cycle it arrives,
// kills the response that lands in that cycle and flushes the skid buffer.
//
// Optional build macro: RISCADO_FETCH_FAULT_EN
//   defined   : PCs at or beyond 4*ROM_LEN raise a sticky fault and stop
//               issue; fault clears on redirect or reset.
//   undefined : fault tied low, no range check.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   rom_enable       out  ROM read strobe
//   rom_address      out  ROM byte address (word aligned)
//   rom_writeEnable  out  tied 0
//   rom_dataIn       out  tied 0
//   rom_dataOut      in   ROM read data, valid the cycle after rom_enable
//   redirect_valid   in   load redirect_pc this cycle
//   redirect_pc      in   new fetch target (bits [1:0] ignored)
//   out_valid        out  instruction available to decode
//   out_ready        in   decode accepts this cycle
//   out_instr        out  instruction word
//   out_pc           out  address of out_instr
//   fault            out  fetch fault
// -----------------------------------------------------------------------------
module instr_fetch
  import riscado_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ROM_LEN  = 10000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  output logic        rom_writeEnable,
  output logic [31:0] rom_dataIn,
  input  logic [31:0] rom_dataOut,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_inflight;

  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_occupancy;
  logic            w_room;
  logic            w_fault_block;
  logic            w_issue;
  logic [XLEN-1:0] w_issue_addr;
  logic [XLEN-1:0] w_redirect_addr;
  logic            w_unused_ok;

  assign w_redirect_addr = word_align(redirect_pc);
  assign w_pop           = out_valid & out_ready;

  // Slots already claimed after this cycle's pop: buffered entries plus the
  // response still on its way from the ROM. Never negative since a pop
  // requires at least one buffered entry.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room      = (w_occupancy < 3'd2);

`ifdef RISCADO_FETCH_FAULT_EN
  localparam logic [63:0] ROM_BYTES = 64'(ROM_LEN) * 64'd4;

  logic r_fault;
  logic w_oob;

  assign w_oob         = ({32'd0, r_pc} >= ROM_BYTES);
  assign w_fault_block = r_fault | w_oob;
  assign fault         = r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= 1'b0;
    end else if (w_oob) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_fault_block = 1'b0;
  assign fault         = 1'b0;
`endif

  // A redirect always issues: the buffer is flushed and the arriving
  // response discarded, so room is guaranteed, and it also clears a fault.
  assign w_issue      = ~reset & (redirect_valid | (~w_fault_block & w_room));
  assign w_issue_addr = redirect_valid ? w_redirect_addr : r_pc;

  assign rom_enable      = w_issue;
  assign rom_address     = w_issue_addr;
  assign rom_writeEnable = 1'b0;
  assign rom_dataIn      = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= word_align(RESET_PC);
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_resp_pc <= w_issue_addr;
        r_pc      <= w_issue_addr + 32'd4;
      end
    end
  end

  // The response arriving in a redirect cycle belongs to the old stream.
  assign w_push       = r_inflight & ~redirect_valid;
  assign w_push_entry = '{pc: r_resp_pc, instr: rom_dataOut};

  fetch_skid_buf #(
    .W (FETCH_ENTRY_W)
  ) u_skid_buf (
    .clk         (clk),
    .i_srst      (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign out_valid = (w_count != 2'd0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  // Byte-offset bits of the redirect target and the ROM size (in the
  // unchecked build) are intentionally not consumed.
  assign w_unused_ok = &{1'b0, redirect_pc[1:0], ROM_LEN[0]};

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Drives instr_fetch against a behavioural ROM (word i = 0x1000_0000 + i).
// The reference model tracks only the architectural streams: the next PC
// decode should receive and the next address the ROM should be asked for.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import riscado_pkg::*;

  localparam int unsigned TB_ROM_LEN = 1024;
  localparam logic [31:0] ROM_LIMIT  = 32'(TB_ROM_LEN * 4);
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_enable;
  logic [31:0] rom_address;
  logic        rom_writeEnable;
  logic [31:0] rom_dataIn;
  logic [31:0] rom_dataOut;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (TB_RESET_PC),
    .ROM_LEN  (TB_ROM_LEN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rom_enable      (rom_enable),
    .rom_address     (rom_address),
    .rom_writeEnable (rom_writeEnable),
    .rom_dataIn      (rom_dataIn),
    .rom_dataOut     (rom_dataOut),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fault           (fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Synchronous ROM: data for the address strobed at edge k is visible after k.
  always @(posedge clk) begin
    if (rom_enable) rom_dataOut <= rom_word(rom_address);
  end

  int n_vec = 0;
  int n_err = 0;

  // Observed outputs of the current cycle
  logic        o_en, o_valid, o_fault;
  logic [31:0] o_addr, o_pc, o_instr;
  // Model state and per-cycle expectations
  logic [31:0] m_pc, m_issue;
  logic        popped;
  logic [31:0] pop_exp_pc, pop_exp_instr, exp_addr;
  // Context of the previous cycle (q_*) and scratch for the current one (l_*)
  logic        q_rst, q_rdir, q_hold;
  logic [31:0] q_pc, q_instr;
  logic        l_rst = 1'b1, l_rdir = 1'b0, l_hold = 1'b0;
  logic [31:0] l_pc = '0, l_instr = '0;

  // Runs one clock cycle with the currently driven inputs: samples outputs
  // mid-cycle and advances the reference model. Performs no comparisons.
  task automatic tick();
    q_rst = l_rst; q_rdir = l_rdir; q_hold = l_hold; q_pc = l_pc; q_instr = l_instr;
    @(negedge clk);
    o_en = rom_enable; o_addr = rom_address; o_valid = out_valid;
    o_pc = out_pc; o_instr = out_instr; o_fault = fault;
    exp_addr = redirect_valid ? align(redirect_pc) : m_issue;
    popped = o_valid & out_ready & ~reset;
    if (popped) begin
      pop_exp_pc    = m_pc;
      pop_exp_instr = rom_word(m_pc);
      m_pc          = m_pc + 32'd4;
    end
    if (o_en && !reset) m_issue = exp_addr + 32'd4;
    if (redirect_valid) m_pc = align(redirect_pc);
    if (reset) begin
      m_pc    = TB_RESET_PC;
      m_issue = TB_RESET_PC;
    end
    l_rst = reset; l_rdir = redirect_valid;
    l_hold = o_valid & ~out_ready & ~redirect_valid & ~reset;
    l_pc = o_pc; l_instr = o_instr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = TB_RESET_PC; m_issue = TB_RESET_PC;
    repeat (3) tick();
    n_vec++;
    if (o_en !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'd0 || o_instr !== 32'd0 || o_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got en=%b valid=%b pc=%h instr=%h fault=%b, expected all zero", o_en, o_valid, o_pc, o_instr, o_fault);
    end
    n_vec++;
    if (rom_writeEnable !== 1'b0 || rom_dataIn !== 32'd0) begin
      n_err++;
      $display("FAIL rom_tieoff: got we=%b din=%h, expected 0/0", rom_writeEnable, rom_dataIn);
    end
    reset = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (o_en !== 1'b1 || o_addr !== TB_RESET_PC) begin
      n_err++;
      $display("FAIL first_issue: got en=%b addr=%h, expected 1/%h", o_en, o_addr, TB_RESET_PC);
    end
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_en !== 1'b1 || o_addr !== 32'd4) begin
      n_err++;
      $display("FAIL latency_t1: got valid=%b en=%b addr=%h, expected 0/1/4", o_valid, o_en, o_addr);
    end
    tick();
    n_vec++;
    if (o_valid !== 1'b1 || o_pc !== 32'd0 || o_instr !== 32'h1000_0000) begin
      n_err++;
      $display("FAIL first_valid: got valid=%b pc=%h instr=%h, expected 1/0/10000000", o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_vec++;
      if (!popped || o_pc !== pop_exp_pc || o_instr !== pop_exp_instr) begin
        n_err++;
        $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h/%h", i, o_valid, o_pc, o_instr, m_pc - 32'd4, rom_word(m_pc - 32'd4));
      end
      n_vec++;
      if (o_en !== 1'b1 || o_addr !== exp_addr) begin
        n_err++;
        $display("FAIL stream_issue[%0d]: got en=%b addr=%h, expected 1/%h", i, o_en, o_addr, exp_addr);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i > 0) begin
        n_vec++;
        if (o_valid !== 1'b1 || o_pc !== q_pc || o_instr !== q_instr) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h/%h", i, o_valid, o_pc, o_instr, q_pc, q_instr);
        end
      end
    end
    n_vec++;
    if (o_en !== 1'b0 || o_addr !== m_issue) begin
      n_err++;
      $display("FAIL stall_freeze: got en=%b addr=%h, expected 0/%h", o_en, o_addr, m_issue);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (!popped || o_pc !== pop_exp_pc || o_instr !== pop_exp_instr) begin
        n_err++;
        $display("FAIL stall_release[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h", i, o_valid, o_pc, o_instr, pop_exp_pc);
      end
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    n_vec++;
    if (o_en !== 1'b1 || o_addr !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL redir_full_issue: got en=%b addr=%h, expected 1/00000100", o_en, o_addr);
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_full_bubble: got valid=%b, expected 0", o_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (!popped || o_pc !== 32'h100 + 32'(i * 4) || o_instr !== rom_word(32'h100 + 32'(i * 4))) begin
        n_err++;
        $display("FAIL redir_full_target[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h", i, o_valid, o_pc, o_instr, 32'h100 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_pop(input logic [31:0] target);
    out_ready = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    n_vec++;
    if (!popped || o_pc !== pop_exp_pc || o_en !== 1'b1 || o_addr !== align(target)) begin
      n_err++;
      $display("FAIL redir_pop_cycle: got valid=%b pc=%h en=%b addr=%h, expected 1/%h/1/%h", o_valid, o_pc, o_en, o_addr, pop_exp_pc, align(target));
    end
    redirect_valid = 1'b0;
    tick();
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_pop_bubble: got valid=%b, expected 0", o_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (!popped || o_pc !== pop_exp_pc || o_instr !== pop_exp_instr) begin
        n_err++;
        $display("FAIL redir_pop_after[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h", i, o_valid, o_pc, o_instr, align(target) + 32'(i * 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (o_en !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_en: got en=%b, expected 0", o_en);
    end
    reset = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_en !== 1'b1 || o_addr !== TB_RESET_PC) begin
      n_err++;
      $display("FAIL midreset_restart: got valid=%b en=%b addr=%h, expected 0/1/%h", o_valid, o_en, o_addr, TB_RESET_PC);
    end
    tick();
    tick();
    n_vec++;
    if (!popped || o_pc !== TB_RESET_PC || o_instr !== rom_word(TB_RESET_PC)) begin
      n_err++;
      $display("FAIL midreset_first: got valid=%b pc=%h instr=%h, expected 1/%h", o_valid, o_pc, o_instr, TB_RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 6);
`ifdef RISCADO_FETCH_FAULT_EN
      redirect_pc    = $urandom_range(0, ROM_LIMIT - 1);
`else
      redirect_pc    = $urandom();
`endif
      tick();
      if (popped) begin
        n_vec++;
        if (o_pc !== pop_exp_pc || o_instr !== pop_exp_instr) begin
          n_err++;
          $display("FAIL rnd_pop[%0d]: got pc=%h instr=%h, expected %h/%h", i, o_pc, o_instr, pop_exp_pc, pop_exp_instr);
        end
      end
      if (reset) begin
        n_vec++;
        if (o_en !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_reset_en[%0d]: got en=%b, expected 0", i, o_en);
        end
      end else if (redirect_valid || o_en) begin
        n_vec++;
        if (o_en !== 1'b1 || o_addr !== exp_addr) begin
          n_err++;
          $display("FAIL rnd_issue[%0d]: got en=%b addr=%h, expected 1/%h", i, o_en, o_addr, exp_addr);
        end
      end
      if (q_rdir || q_rst) begin
        n_vec++;
        if (o_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_bubble[%0d]: got valid=%b, expected 0", i, o_valid);
        end
      end
      if (q_hold) begin
        n_vec++;
        if (o_valid !== 1'b1 || o_pc !== q_pc || o_instr !== q_instr) begin
          n_err++;
          $display("FAIL rnd_hold[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h/%h", i, o_valid, o_pc, o_instr, q_pc, q_instr);
        end
      end
    end
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
  endtask

`ifndef RISCADO_FETCH_FAULT_EN
  task automatic test_wrap();
    test_redirect_pop(32'hFFFF_FFF9);
  endtask
`else
  task automatic test_fault();
    int n_pops;
    n_pops = 0;
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = ROM_LIMIT - 32'd16;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_en && m_issue >= ROM_LIMIT + 32'd4) begin
        n_vec++;
        n_err++;
        $display("FAIL fault_issue[%0d]: got en=1 addr=%h, expected no issue beyond %h", i, o_addr, ROM_LIMIT);
      end
      if (popped) begin
        n_pops++;
        n_vec++;
        if (o_pc !== pop_exp_pc) begin
          n_err++;
          $display("FAIL fault_drain[%0d]: got pc=%h, expected %h", i, o_pc, pop_exp_pc);
        end
      end
    end
    n_vec++;
    if (o_fault !== 1'b1 || o_en !== 1'b0 || n_pops != 4) begin
      n_err++;
      $display("FAIL fault_set: got fault=%b en=%b pops=%0d, expected 1/0/4", o_fault, o_en, n_pops);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    n_vec++;
    if (o_en !== 1'b1 || o_addr !== 32'd0) begin
      n_err++;
      $display("FAIL fault_redir_issue: got en=%b addr=%h, expected 1/0", o_en, o_addr);
    end
    redirect_valid = 1'b0;
    tick();
    n_vec++;
    if (o_fault !== 1'b0) begin
      n_err++;
      $display("FAIL fault_clear: got fault=%b, expected 0", o_fault);
    end
    tick();
    n_vec++;
    if (!popped || o_pc !== 32'd0) begin
      n_err++;
      $display("FAIL fault_resume: got valid=%b pc=%h, expected 1/0", o_valid, o_pc);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop(32'h0000_0800 + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3)));
    test_reset_mid();
`ifndef RISCADO_FETCH_FAULT_EN
    test_wrap();
`else
    test_fault();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
